// File: rtl/order_link_arbiter.sv
// order_link_arbiter: round-robin sharing of one serial order link with inter-order gap, watchdog and counters
module order_link_arbiter #(
    parameter int NREQ           = 2,
    parameter int W              = 32,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              CPU_RESETN,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_order,
    output logic [NREQ-1:0]   req_ack,
    output logic              tx_start,
    output logic [W-1:0]      tx_data,
    input  logic              tx_done,
    output logic [1:0]        grant_id,
    output logic              busy,
    output logic [15:0]       sent_count,
    output logic              err_timeout,
    input  logic              err_clear
);
    localparam int CMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_DONE, GAP} state_t;

    state_t        state, state_nx;
    logic [1:0]    rr_ptr, win;
    logic [CW-1:0] cnt, cnt_inc;
    logic          timed_out, gap_end;

    assign cnt_inc   = cnt + 1'b1;
    assign timed_out = state == WAIT_DONE && !tx_done && cnt_inc == CW'(TIMEOUT_CYCLES - 1);
    assign gap_end   = cnt_inc == CW'(GAP_CYCLES);

    // Scan from the highest offset down so the nearest valid requester after rr_ptr wins last
    always_comb begin
        win = rr_ptr;
        for (int i = NREQ - 1; i >= 0; i--)
            if (|(req_valid & (NREQ'(1) << ((int'(rr_ptr) + i) % NREQ))))
                win = 2'((int'(rr_ptr) + i) % NREQ);
    end

    always_ff @(posedge clk or negedge CPU_RESETN)
        if (!CPU_RESETN) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = |req_valid ? GRANT : IDLE;
            GRANT:     state_nx = START;
            START:     state_nx = WAIT_DONE;
            WAIT_DONE: state_nx = (tx_done || timed_out) ? (GAP_CYCLES == 0 ? IDLE : GAP) : WAIT_DONE;
            GAP:       state_nx = gap_end ? IDLE : GAP;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ack  = state == GRANT ? NREQ'(1) << grant_id : '0;
        tx_start = state == START;
        busy     = state != IDLE;
    end

    // One counter serves both the watchdog and the gap; it restarts whenever the state changes
    always_ff @(posedge clk or negedge CPU_RESETN)
        if (!CPU_RESETN) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            tx_data     <= '0;
            cnt         <= '0;
            sent_count  <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == IDLE && |req_valid) begin
                grant_id <= win;
                rr_ptr   <= 2'((int'(win) + 1) % NREQ);
            end
            if (state == GRANT) tx_data <= W'(req_order >> (int'(grant_id) * W));
            cnt <= ((state == WAIT_DONE || state == GAP) && state_nx == state) ? cnt_inc : '0;
            if (state == WAIT_DONE && tx_done) sent_count <= sent_count + 1'b1;
            err_timeout <= timed_out || (err_timeout && !err_clear);
        end
endmodule

// File: tb/tb_order_link_arbiter.sv
// tb_order_link_arbiter: scoreboard-driven checks of grant order, latency, watchdog, gap and reset
module tb_order_link_arbiter;
    localparam int NREQ = 2, W = 32, GAP = 4, TO = 16;

    logic              clk = 0, CPU_RESETN = 0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_order = '0;
    logic [NREQ-1:0]   req_ack;
    logic              tx_start, busy, err_timeout;
    logic              tx_done = 0, err_clear = 0;
    logic [W-1:0]      tx_data;
    logic [1:0]        grant_id;
    logic [15:0]       sent_count;

    typedef struct packed {logic [1:0] id; logic [W-1:0] data;} exp_t;
    exp_t sb[$];
    exp_t e;
    int n_checks = 0, n_fail = 0;

    order_link_arbiter #(.NREQ(NREQ), .W(W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .CPU_RESETN(CPU_RESETN), .req_valid(req_valid), .req_order(req_order),
        .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .sent_count(sent_count),
        .err_timeout(err_timeout), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for_ack(output bit seen);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++)
            if (req_ack != '0) seen = 1;
            else tick();
    endtask

    task automatic test_reset();
        CPU_RESETN = 0; req_valid = '0; tx_done = 0; err_clear = 0;
        repeat (2) tick();
        n_checks++;
        if ({req_ack, tx_start, busy, tx_data, grant_id, sent_count, err_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: ack=%b start=%b busy=%b data=%h gid=%0d cnt=%0d err=%b, required all zero",
                     req_ack, tx_start, busy, tx_data, grant_id, sent_count, err_timeout);
        end
        CPU_RESETN = 1;
        tick();
    endtask

    task automatic test_single();
        req_order[31:0] = 32'h1100_4001;
        req_valid = 2'b01;
        sb.push_back({2'd0, 32'h1100_4001});
        tick();
        n_checks++;
        if (req_ack !== 2'b01 || tx_start !== 1'b0) begin
            n_fail++; $display("FAIL single_ack: ack=%b start=%b, required ack=01 start=0", req_ack, tx_start);
        end
        req_valid = '0;
        tick();
        e = sb.pop_front();
        n_checks++;
        if (tx_start !== 1'b1 || req_ack !== 2'b00) begin
            n_fail++; $display("FAIL single_start: start=%b ack=%b, required start=1 ack=00", tx_start, req_ack);
        end
        n_checks++;
        if (tx_data !== e.data || grant_id !== e.id) begin
            n_fail++; $display("FAIL single_data: data=%h gid=%0d, required data=%h gid=%0d", tx_data, grant_id, e.data, e.id);
        end
        req_order[31:0] = 32'hDEAD_BEEF;
        repeat (9) tick();
        n_checks++;
        if (tx_data !== e.data) begin
            n_fail++; $display("FAIL single_latched: data=%h, required %h", tx_data, e.data);
        end
        tx_done = 1; tick(); tx_done = 0;
        n_checks++;
        if (sent_count !== 16'd1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_done: cnt=%0d busy=%b, required cnt=1 busy=1", sent_count, busy);
        end
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL single_gap_busy: busy=%b, required 1", busy);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL single_gap_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_contention();
        bit seen;
        int acks[2];
        acks = '{0, 0};
        test_reset();
        for (int k = 0; k < 6; k++)
            sb.push_back({2'(k % 2), ((k % 2) != 0 ? 32'hB000_0000 : 32'hA000_0000) + 32'(k / 2)});
        req_order = {32'hB000_0000, 32'hA000_0000};
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_for_ack(seen);
            n_checks++;
            if (!seen) begin
                n_fail++; $display("FAIL cont_ack_wait: no ack for grant %0d, required one within 40 cycles", k);
                break;
            end
            n_checks++;
            if (req_ack !== (2'b01 << sb[0].id) || tx_start !== 1'b0) begin
                n_fail++; $display("FAIL cont_ack: grant %0d ack=%b start=%b, required ack=%b start=0", k, req_ack, tx_start, 2'b01 << sb[0].id);
            end
            if (req_ack[0]) acks[0]++;
            if (req_ack[1]) acks[1]++;
            tick();
            e = sb.pop_front();
            if (e.id == 2'd0) req_order[31:0] = e.data + 1;
            else req_order[63:32] = e.data + 1;
            n_checks++;
            if (tx_start !== 1'b1 || req_ack !== 2'b00 || tx_data !== e.data || grant_id !== e.id) begin
                n_fail++; $display("FAIL cont_start: grant %0d start=%b ack=%b data=%h gid=%0d, required start=1 ack=00 data=%h gid=%0d",
                                   k, tx_start, req_ack, tx_data, grant_id, e.data, e.id);
            end
            repeat (4) tick();
            tx_done = 1; tick(); tx_done = 0;
            n_checks++;
            if (sent_count !== 16'(k + 1)) begin
                n_fail++; $display("FAIL cont_count: grant %0d cnt=%0d, required %0d", k, sent_count, k + 1);
            end
        end
        req_valid = '0;
        repeat (5) tick();
        n_checks++;
        if (acks[0] != 3 || acks[1] != 3 || sb.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cont_summary: acks=%0d/%0d left=%0d busy=%b, required 3/3 0 0", acks[0], acks[1], sb.size(), busy);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        logic [15:0] sc;
        sc = sent_count;
        req_order[31:0] = 32'h7000_0001;
        req_valid = 2'b01;
        sb.push_back({2'd0, 32'h7000_0001});
        wait_for_ack(seen);
        req_valid = '0;
        n_checks++;
        if (!seen || req_ack !== 2'b01) begin
            n_fail++; $display("FAIL to_ack: seen=%b ack=%b, required ack=01", seen, req_ack);
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== e.data) begin
            n_fail++; $display("FAIL to_start: start=%b data=%h, required start=1 data=%h", tx_start, tx_data, e.data);
        end
        for (int c = 1; c <= 16; c++) begin
            err_clear = (c == 16);
            tick();
            n_checks++;
            if (err_timeout !== (c == 16)) begin
                n_fail++; $display("FAIL to_flag: %0d cycles after start err=%b, required %b", c, err_timeout, c == 16);
            end
        end
        err_clear = 0;
        n_checks++;
        if (sent_count !== sc || busy !== 1'b1) begin
            n_fail++; $display("FAIL to_count: cnt=%0d busy=%b, required cnt=%0d busy=1", sent_count, busy, sc);
        end
        tick();
        n_checks++;
        if (err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL to_sticky: err=%b, required 1", err_timeout);
        end
        req_order[63:32] = 32'h7000_0002;
        req_valid = 2'b10;
        sb.push_back({2'd1, 32'h7000_0002});
        wait_for_ack(seen);
        req_valid = '0;
        n_checks++;
        if (!seen || req_ack !== 2'b10) begin
            n_fail++; $display("FAIL to_next_ack: seen=%b ack=%b, required ack=10", seen, req_ack);
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== e.data || grant_id !== e.id) begin
            n_fail++; $display("FAIL to_next_start: start=%b data=%h gid=%0d, required start=1 data=%h gid=%0d", tx_start, tx_data, grant_id, e.data, e.id);
        end
        repeat (2) tick();
        tx_done = 1; tick(); tx_done = 0;
        n_checks++;
        if (sent_count !== sc + 16'd1 || err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL to_next_done: cnt=%0d err=%b, required cnt=%0d err=1", sent_count, err_timeout, sc + 16'd1);
        end
        err_clear = 1; tick(); err_clear = 0;
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_clear: err=%b, required 0", err_timeout);
        end
        repeat (5) tick();
    endtask

    task automatic test_early_done();
        bit seen;
        logic [15:0] sc;
        sc = sent_count;
        req_order[31:0] = 32'h5500_0001;
        req_valid = 2'b01;
        sb.push_back({2'd0, 32'h5500_0001});
        wait_for_ack(seen);
        req_valid = '0;
        tick();
        e = sb.pop_front();
        n_checks++;
        if (!seen || tx_start !== 1'b1 || tx_data !== e.data) begin
            n_fail++; $display("FAIL early_start: seen=%b start=%b data=%h, required start=1 data=%h", seen, tx_start, tx_data, e.data);
        end
        tx_done = 1; tick(); tx_done = 0;
        repeat (5) tick();
        n_checks++;
        if (sent_count !== sc || busy !== 1'b1) begin
            n_fail++; $display("FAIL early_ignored: cnt=%0d busy=%b, required cnt=%0d busy=1", sent_count, busy, sc);
        end
        tx_done = 1; tick(); tx_done = 0;
        n_checks++;
        if (sent_count !== sc + 16'd1) begin
            n_fail++; $display("FAIL early_done: cnt=%0d, required %0d", sent_count, sc + 16'd1);
        end
        repeat (4) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL early_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        req_order[31:0] = 32'h6600_0001;
        req_valid = 2'b01;
        wait_for_ack(seen);
        req_valid = '0;
        repeat (4) tick();
        #2 CPU_RESETN = 0;
        #1;
        n_checks++;
        if ({req_ack, tx_start, busy, tx_data, grant_id, sent_count, err_timeout} !== '0) begin
            n_fail++; $display("FAIL mid_reset_async: ack=%b start=%b busy=%b data=%h gid=%0d cnt=%0d err=%b, required all zero",
                               req_ack, tx_start, busy, tx_data, grant_id, sent_count, err_timeout);
        end
        repeat (3) tick();
        CPU_RESETN = 1;
        tick();
        n_checks++;
        if (req_ack !== 2'b00 || tx_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_release: ack=%b start=%b busy=%b, required 00 0 0", req_ack, tx_start, busy);
        end
        req_order[63:32] = 32'h6600_0002;
        req_valid = 2'b10;
        sb.push_back({2'd1, 32'h6600_0002});
        wait_for_ack(seen);
        req_valid = '0;
        n_checks++;
        if (!seen || req_ack !== 2'b10 || grant_id !== 2'd1) begin
            n_fail++; $display("FAIL mid_ack: seen=%b ack=%b gid=%0d, required ack=10 gid=1", seen, req_ack, grant_id);
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== e.data) begin
            n_fail++; $display("FAIL mid_start: start=%b data=%h, required start=1 data=%h", tx_start, tx_data, e.data);
        end
        repeat (3) tick();
        tx_done = 1; tick(); tx_done = 0;
        n_checks++;
        if (sent_count !== 16'd1) begin
            n_fail++; $display("FAIL mid_count: cnt=%0d, required 1", sent_count);
        end
        repeat (5) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_early_done();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/order_link_arbiter.md
Name: order_link_arbiter

Overview:
- Shares the single outbound order link (the serial `communicate` transmitter) between NREQ order sources, e.g. the VGA/PS2 order-entry UI and the automated strategy engine.
- Picks one pending order at a time using round-robin arbitration.
- Latches the order, launches one transmission, and waits for completion or a watchdog timeout.
- Enforces a minimum inter-order gap and keeps a sent-order count and a sticky timeout flag.

Parameters:
NREQ, 2, number of requesters (2..4)
W, 32, order word width
GAP_CYCLES, 4, idle cycles forced between the end of one transmission and the next grant (0 = no gap)
TIMEOUT_CYCLES, 4096, maximum WAIT_DONE cycles before the transmission is abandoned

Ports:
clk  in  1  system clock; all state updates on posedge
CPU_RESETN  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester order pending; held high until acked
req_order  in  NREQ*W  requester i's order in bits [i*W+W-1 : i*W]
req_ack  out  NREQ  one-cycle pulse to the granted requester when its order is latched
tx_start  out  1  one-cycle pulse launching the serializer
tx_data  out  W  latched order, stable from GRANT+1 until leaving WAIT_DONE
tx_done  in  1  serializer completion pulse
grant_id  out  2  index of the current or last granted requester
busy  out  1  high in every state except IDLE
sent_count  out  16  number of completed transmissions; wraps 0xFFFF -> 0
err_timeout  out  1  sticky: a transmission timed out
err_clear  in  1  clears err_timeout

Behaviour:
- Reset (async, CPU_RESETN=0) values:
  - state=IDLE, rr_ptr=0
  - req_ack=0, tx_start=0, tx_data=0, grant_id=0, busy=0
  - sent_count=0, err_timeout=0, all counters 0
- States:
  - IDLE -> GRANT when any req_valid is high.
  - GRANT (1 cycle):
    - req_ack[g]=1 for the winner g; tx_data <= req_order slice g; grant_id <= g; rr_ptr <= (g+1) mod NREQ.
    - Next state START.
  - START (1 cycle): tx_start=1. Next state WAIT_DONE; the timeout counter clears to 0.
  - WAIT_DONE:
    - tx_done=1 -> sent_count+1, go to GAP.
    - Otherwise the counter increments; when it reaches TIMEOUT_CYCLES-1 with no done, set err_timeout, go to GAP, and do not increment sent_count.
    - tx_done is sampled only in WAIT_DONE; a done pulse in GRANT or START is ignored.
  - GAP:
    - Counts GAP_CYCLES cycles, then goes to IDLE.
    - With GAP_CYCLES=0, WAIT_DONE goes directly to IDLE.
- Arbitration:
  - Winner = first requester with valid=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Evaluated combinationally in the IDLE cycle and registered into GRANT.
- Latency: req_valid seen in IDLE at edge n -> req_ack high in cycle n+1 -> tx_start high in cycle n+2.
- Requester rules:
  - The requester drops or updates valid the cycle after ack.
  - A requester still valid after ack is treated as a new order.
  - req_order changes after ack do not affect tx_data.
- Only one of req_ack, tx_start is high in any cycle; req_ack is one-hot or zero.
- err_timeout: set has priority over err_clear in the same cycle. err_clear otherwise clears it in the next cycle. The flag is cleared only by err_clear or reset.
- Reset asserted mid-transfer: everything returns to reset values immediately. No ack or start is re-issued after release until a new IDLE evaluation.
- All outputs are registered or decoded from registered state; no combinational path from req_valid to req_ack.

Test Plan:
- Single request: req_valid=01, order0=0x11004001 -> ack[0] in cycle 1, tx_start in cycle 2, tx_data=0x11004001; done after 10 cycles -> sent_count=1, busy low after 4 gap cycles.
- Contention: both valid continuously, done returned 5 cycles after each start -> grants alternate 0,1,0,1; grant_id follows; each ack fires exactly once per grant.
- Timeout: TIMEOUT_CYCLES=16, tx_done never asserted -> err_timeout=1 exactly 16 cycles after START, sent_count unchanged, next grant proceeds; err_clear then drops the flag.
- Set/clear collision: timeout and err_clear in the same cycle -> err_timeout remains 1.
- Early done: tx_done pulsed during the START cycle -> ignored; FSM waits for the next done pulse.
- Reset mid-WAIT_DONE: CPU_RESETN low for 3 cycles -> outputs at reset values asynchronously, sent_count=0, rr_ptr=0; the next request to requester 1 (only valid) is granted normally.
